inst_rom_loader: RTL

- Byte-stream boot loader. Programs the 64-entry instruction memory through its write port, so the fetch stage later reads the loaded program.
- Accepts a framed byte stream over a valid/ready handshake: count byte, big-endian 32-bit words, XOR checksum byte.
- Holds the CPU while a load is in progress.
- Reports completion and checksum error.

---
 rtl/inst_rom_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/inst_rom_loader.sv
// Byte-stream boot loader for the 64-entry instruction memory.
// Frame layout: count byte, big-endian 32-bit words, XOR checksum byte.
// The CPU is held while a frame is being loaded. Completion is signalled
// with a one-cycle done pulse, and err reports a checksum mismatch.
module inst_rom_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so that a full-depth word count (DEPTH) is representable.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  words;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        bidx;
  logic [23:0]       shreg;
  logic [7:0]        xsum;
  logic              accept;

  assign accept = in_valid & in_ready;

  // A count of zero means a full memory; anything above DEPTH is clamped.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [7:0] n);
    if (n == 8'd0 || {1'b0, n} > 9'(DEPTH))
      return CNT_W'(DEPTH);
    return CNT_W'(n);
  endfunction

  // Loader state machine; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      words    <= '0;
      widx     <= '0;
      bidx     <= '0;
      shreg    <= '0;
      xsum     <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_req) begin
            state    <= S_COUNT;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            err      <= 1'b0;
            widx     <= '0;
            bidx     <= '0;
            xsum     <= '0;
          end
        end
        S_COUNT: begin
          // The count byte is deliberately kept out of the checksum.
          if (accept) begin
            words <= clamp_count(in_data);
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            xsum  <= xsum ^ in_data;
            shreg <= {shreg[15:0], in_data};
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              // Fourth byte completes the word: present it next cycle.
              we       <= 1'b1;
              waddr    <= widx;
              wdata    <= {shreg, in_data};
              in_ready <= 1'b0;
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          widx     <= widx + ADDR_W'(1);
          bidx     <= '0;
          in_ready <= 1'b1;
          if ((CNT_W'(widx) + CNT_W'(1)) == words)
            state <= S_CHECK;
          else
            state <= S_DATA;
        end
        S_CHECK: begin
          if (accept) begin
            err      <= (in_data != xsum);
            in_ready <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          // Hold stays asserted through the done cycle and drops after it.
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
